// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
//
// Contents:
//   arb_state_e   - arbiter FSM state (IDLE -> ACCESS -> RESP -> IDLE)
//   arb_own_e     - which requester owns the current transaction
//   addr_oob()    - true when a word address is outside the memory
//
// Optional feature macro used by the files importing this package:
//   ARB_ROUND_ROBIN_EN - alternate grants when both ports request together
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_own_e;

  function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] size);
    return (addr >= size);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational owner picker for the memory port arbiter.
//
// Ports:
//   i_req_i   - instruction fetch port is requesting
//   d_req_i   - data port is requesting
//   rr_ptr_i  - round-robin preference (0 = instr next, 1 = data next)
//   grant_o   - at least one port is requesting
//   owner_o   - port that wins this cycle
//
// Macro ARB_ROUND_ROBIN_EN: when defined, rr_ptr_i breaks ties; otherwise
// the data port always wins a tie and rr_ptr_i is ignored.
module arb_priority_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  logic     rr_ptr_i,
  output logic     grant_o,
  output arb_own_e owner_o
);

  assign grant_o = i_req_i | d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    owner_o = ARB_OWN_I;
    if (i_req_i && d_req_i) begin
      owner_o = rr_ptr_i ? ARB_OWN_D : ARB_OWN_I;
    end else if (d_req_i) begin
      owner_o = ARB_OWN_D;
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr_i;

  always_comb begin
    owner_o = d_req_i ? ARB_OWN_D : ARB_OWN_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between
// the instruction-fetch port and the data (load/store) port.
//
// Ports:
//   clk, reset                - clock (rising edge), async active-low reset
//   i_req/i_addr              - fetch request, held until i_ack
//   i_ack/i_rdata             - one-cycle ack, fetched word (held until next i_ack)
//   d_req/d_we/d_addr/d_wdata - data request, held until d_ack
//   d_ack/d_rdata             - one-cycle ack, load word (held until next d_ack)
//   addr_err                  - pulses with the ack when the address is >= MEM_SIZE
//   mem_addr/mem_read_en/mem_write_en/mem_write_val/mem_read_val - memory side
//   dbg_state                 - current FSM state
//
// Handshake: a request is sampled only in IDLE; once granted, the fields are
// latched, later changes (including dropping req) are ignored, and the owner
// sees exactly one ack pulse two cycles after the grant edge.
//
// Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests alternate
// via a 1-bit pointer that toggles on every grant; otherwise data wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_ack,
  output logic [MEM_WIDTH-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  logic [MEM_WIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic [MEM_WIDTH-1:0] d_rdata,
  output logic                 addr_err,
  output logic [31:0]          mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val,
  output arb_state_e           dbg_state
);

  arb_state_e           state_q;
  arb_own_e             owner_q;
  logic                 we_q;
  logic                 err_q;
  logic [31:0]          addr_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic                 rd_en_q;
  logic                 wr_en_q;
  logic                 i_ack_q;
  logic                 d_ack_q;
  logic                 err_pulse_q;
  logic [MEM_WIDTH-1:0] i_rdata_q;
  logic [MEM_WIDTH-1:0] d_rdata_q;
  logic                 rr_ptr;

  logic                 grant;
  arb_own_e             pick_owner;
  logic                 pick_we;
  logic [31:0]          pick_addr;
  logic                 pick_err;
  logic [MEM_WIDTH-1:0] resp_val;
  logic                 i_resp;
  logic                 d_resp;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q;
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  arb_priority_pick u_pick (
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .rr_ptr_i (rr_ptr),
    .grant_o  (grant),
    .owner_o  (pick_owner)
  );

  assign pick_we   = (pick_owner == ARB_OWN_D) && d_we;
  assign pick_addr = (pick_owner == ARB_OWN_D) ? d_addr : i_addr;
  assign pick_err  = addr_oob(pick_addr, 32'(MEM_SIZE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_I;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant) begin
            owner_q <= pick_owner;
            we_q    <= pick_we;
            err_q   <= pick_err;
            addr_q  <= pick_addr;
            wdata_q <= d_wdata;
            // Out-of-range accesses never touch the memory.
            rd_en_q <= !pick_we && !pick_err;
            wr_en_q <= pick_we && !pick_err;
            state_q <= ARB_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= ~rr_q;
`endif
          end
        end
        ARB_ACCESS: begin
          i_ack_q     <= (owner_q == ARB_OWN_I);
          d_ack_q     <= (owner_q == ARB_OWN_D);
          err_pulse_q <= err_q;
          state_q     <= ARB_RESP;
        end
        ARB_RESP: begin
          if (i_resp) i_rdata_q <= resp_val;
          if (d_resp) d_rdata_q <= resp_val;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // The memory word only becomes valid in the RESP cycle, the same cycle the
  // ack is shown, so rdata passes it through then and holds the captured
  // copy from then on.
  assign resp_val = err_q ? '0 : mem_read_val;
  assign i_resp   = (state_q == ARB_RESP) && (owner_q == ARB_OWN_I);
  assign d_resp   = (state_q == ARB_RESP) && (owner_q == ARB_OWN_D) && !we_q;

  assign i_rdata       = i_resp ? resp_val : i_rdata_q;
  assign d_rdata       = d_resp ? resp_val : d_rdata_q;
  assign i_ack         = i_ack_q;
  assign d_ack         = d_ack_q;
  assign addr_err      = err_pulse_q;
  assign mem_addr      = addr_q;
  assign mem_read_en   = rd_en_q;
  assign mem_write_en  = wr_en_q;
  assign mem_write_val = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the arbiter plus a shadow of
// the memory contents. Define ARB_ROUND_ROBIN_EN to check the alternating build.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W    = 32;
  localparam int SIZE = 256;

  logic         clk;
  logic         reset;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_ack;
  logic [W-1:0] i_rdata;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [W-1:0] d_wdata;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         addr_err;
  logic [31:0]  mem_addr;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [W-1:0] mem_write_val;
  logic [W-1:0] mem_read_val;
  arb_state_e   dbg_state;

  mem_port_arbiter #(.MEM_WIDTH(W), .MEM_SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory instance (environment) ----------------
  logic [W-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[7:0]] <= mem_write_val;
    if (mem_read_en)  mem_read_val <= mem[mem_addr[7:0]];
  end

  // ---------------- reference model state ----------------
  logic [W-1:0] ref_mem [SIZE];
  logic [W-1:0] exp_i_rdata;
  logic [W-1:0] exp_d_rdata;
  bit           m_ptr_d;        // 1 = data port preferred on the next tie
  bit           last_owner_d;
  int           n_pass;
  int           n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One transaction from IDLE using the request inputs as currently driven.
  // Called at posedge+1. drop: requests drop and fields change right after grant.
  task automatic run_txn(input bit drop);
    bit           own_d;
    bit           we;
    bit           err;
    logic [31:0]  a;
    logic [W-1:0] wd;
    logic [W-1:0] exp_rd;
    chk("idle_before_req", 32'(dbg_state), 32'(ARB_IDLE));
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      own_d = m_ptr_d;
`else
      own_d = 1'b1;
`endif
    end else begin
      own_d = d_req;
    end
`ifdef ARB_ROUND_ROBIN_EN
    m_ptr_d = ~m_ptr_d;
`endif
    a   = own_d ? d_addr : i_addr;
    we  = own_d && d_we;
    err = (a >= 32'(SIZE));
    wd  = d_wdata;
    last_owner_d = own_d;

    @(posedge clk); #1;
    if (drop) begin
      i_req   = 1'b0;
      d_req   = 1'b0;
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_we    = ~d_we;
      d_wdata = $urandom;
    end

    @(negedge clk);  // ACCESS cycle
    chk("access_read_en",  32'(mem_read_en),  32'(!we && !err));
    chk("access_write_en", 32'(mem_write_en), 32'(we && !err));
    if (!err) chk("access_addr", mem_addr, a);
    if (we && !err) chk("access_wval", mem_write_val, wd);
    chk("access_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
    chk("access_i_hold", i_rdata, exp_i_rdata);
    chk("access_d_hold", d_rdata, exp_d_rdata);
    if (we && !err) ref_mem[a[7:0]] = wd;
    exp_rd = err ? '0 : ref_mem[a[7:0]];

    @(negedge clk);  // RESP cycle
    chk("resp_i_ack",    32'(i_ack),    32'(!own_d));
    chk("resp_d_ack",    32'(d_ack),    32'(own_d));
    chk("resp_addr_err", 32'(addr_err), 32'(err));
    chk("resp_no_strobe", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    if (!own_d) exp_i_rdata = exp_rd;
    else if (!we) exp_d_rdata = exp_rd;
    chk("resp_i_rdata", i_rdata, exp_i_rdata);
    chk("resp_d_rdata", d_rdata, exp_d_rdata);
    @(posedge clk); #1;
  endtask

  task automatic set_i(input bit r, input logic [31:0] a);
    i_req = r; i_addr = a;
  endtask

  task automatic set_d(input bit r, input bit we, input logic [31:0] a, input logic [W-1:0] wd);
    d_req = r; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acks"}, {29'd0, i_ack, d_ack, addr_err}, 32'd0);
    chk({tag, "_strobes"}, {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wval"}, mem_write_val, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ARB_IDLE));
  endtask

  initial begin
    bit exp_seq [4];
    n_pass = 0; n_total = 0;
    m_ptr_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0; last_owner_d = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      ref_mem[k] = $urandom;
      mem[k]     = ref_mem[k];
    end
    ref_mem[212] = 32'h2010_0004;
    mem[212]     = 32'h2010_0004;

    // ---- reset values ----
    reset = 1'b0;
    set_i(0, 0);
    set_d(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // ---- reset in the middle of a data write: aborted, no ack ----
    set_d(1, 1, 20, 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_write_en", 32'(mem_write_en), 32'd1);
    reset = 1'b0;
    #1 check_all_zero("abort");
    set_d(0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(d_ack), 32'd0);
    end
    reset = 1'b1;
    m_ptr_d = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", 32'(dbg_state), 32'(ARB_IDLE));
    chk("abort_mem_untouched", mem[20], ref_mem[20]);

    // ---- single fetch from 212 ----
    set_i(1, 212);
    run_txn(0);
    chk("fetch_212", i_rdata, 32'h2010_0004);
    set_i(0, 0);

    // ---- both ports held for four transactions ----
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t < 4; t++) begin
      set_i(1, 32'(t + 40));
      set_d(1, 0, 32'(t + 60), 0);
      run_txn(0);
      chk("tie_order", 32'(last_owner_d), 32'(exp_seq[t]));
    end
    set_i(0, 0);
    set_d(0, 0, 0, 0);

    // ---- write then read back ----
    set_d(1, 1, 10, 32'hDEAD_BEEF);
    run_txn(0);
    set_d(1, 0, 10, 0);
    run_txn(0);
    chk("readback_10", d_rdata, 32'hDEAD_BEEF);

    // ---- out-of-range read at MEM_SIZE and last legal word ----
    set_d(1, 0, 256, 0);
    run_txn(0);
    chk("oob_rdata", d_rdata, 32'd0);
    set_d(1, 0, 255, 0);
    run_txn(0);
    set_d(1, 1, 300, 32'hFFFF_0000);
    run_txn(0);
    set_d(0, 0, 0, 0);

    // ---- fetch dropped right after grant ----
    set_i(1, 33);
    run_txn(1);
    repeat (2) begin
      @(negedge clk);
      chk("drop_stays_idle", 32'(dbg_state), 32'(ARB_IDLE));
      chk("drop_no_strobe", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    end
    @(posedge clk); #1;

    // ---- random traffic ----
    for (int t = 0; t < 40; t++) begin
      bit ir;
      bit dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      set_i(ir, ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 260)) : 32'($urandom_range(0, 31)));
      set_d(dr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 260)) : 32'($urandom_range(0, 31)),
            $urandom);
      run_txn(1'($urandom_range(0, 3) == 0));
      set_i(0, 0);
      set_d(0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
